// File: rtl/bus_timer_pkg.sv
// -----------------------------------------------------------------------------
// bus_timer_pkg
// Shared definitions for the memory-mapped bus timer: data bus width, register
// word offsets inside the timer window, CTRL/STATUS bit positions and the
// packed view of the CTRL register.
// -----------------------------------------------------------------------------
`ifndef DATABUS
`define DATABUS 16
`endif

package bus_timer_pkg;

  // Width of the SoC data bus; the timer counter and reload share it.
  localparam int DATABUS_W = `DATABUS;

  // Word offsets inside the timer address window.
  localparam logic [2:0] TMR_CTRL   = 3'd0;
  localparam logic [2:0] TMR_PRESC  = 3'd1;
  localparam logic [2:0] TMR_RELOAD = 3'd2;
  localparam logic [2:0] TMR_COUNT  = 3'd3;
  localparam logic [2:0] TMR_STATUS = 3'd4;

  // CTRL bit indices.
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  // STATUS bit index.
  localparam int STATUS_PEND = 0;

  // Packed CTRL register; field order matches the bit indices above.
  typedef struct packed {
    logic ie;
    logic auto_rl;
    logic en;
  } ctrl_t;

endpackage : bus_timer_pkg

// File: rtl/bus_timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Divides the system clock into a one-cycle tick every (presc + 1) cycles while
// enabled. The internal count is held at zero while disabled and can be forced
// back to zero with clr so a freshly started or re-programmed timer always
// begins a full prescaler period.
//
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   en     in  prescaler enable (CTRL.EN)
//   clr    in  restart request, forces the count to zero on the next edge
//   presc  in  terminal count; tick period is presc + 1 cycles
//   tick   out one-cycle pulse, high in the cycle where the count equals presc
// -----------------------------------------------------------------------------
module timer_prescaler
  import bus_timer_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt_q;
  logic [PRESC_W-1:0] pcnt_d;
  logic               at_top_s;

  assign at_top_s = (pcnt_q == presc);

  // The tick is evaluated on the current count, so a clr in the same cycle
  // only affects where the next period starts, not this cycle's tick.
  assign tick = en & at_top_s;

  // Next prescaler count: hold at zero when idle, restart on clr, wrap at presc.
  always_comb begin
    pcnt_d = pcnt_q;
    if (!en) begin
      pcnt_d = '0;
    end else if (clr) begin
      pcnt_d = '0;
    end else if (at_top_s) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PRESC_W'(1);
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule : timer_prescaler

// File: rtl/bus_timer.sv
// -----------------------------------------------------------------------------
// bus_timer
// Memory-mapped 16-bit down-counting timer with programmable prescaler, reload
// value, one-shot / auto-reload mode and a sticky write-1-to-clear pending flag
// that raises the level interrupt int_timer when enabled.
//
// Register map (word offset):
//   0 CTRL   : bit0 EN, bit1 AUTO, bit2 IE
//   1 PRESC  : prescaler terminal count (tick period PRESC + 1)
//   2 RELOAD : value loaded into COUNT on expiry in auto-reload mode
//   3 COUNT  : current counter, writable
//   4 STATUS : bit0 PEND, write 1 to clear
//   5-7      : read as zero, writes ignored
//
// Ports:
//   clk       in  system clock, rising edge
//   rst_n     in  asynchronous active-low reset
//   sel       in  block select from the BUS address decoder
//   we        in  write strobe, qualified by sel
//   addr      in  word offset inside the timer window
//   wdata     in  write data
//   rdata     out read data, zero-latency mux of the registers, 0 when !sel
//   int_timer out level interrupt request (PEND & IE), registered
// -----------------------------------------------------------------------------
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int DATA_W  = DATABUS_W,
  parameter int PRESC_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              we,
  input  logic [2:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              int_timer
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ctrl_t              ctrl_q,   ctrl_d;
  logic [PRESC_W-1:0] presc_q,  presc_d;
  logic [DATA_W-1:0]  reload_q, reload_d;
  logic [DATA_W-1:0]  count_q,  count_d;
  logic               pend_q,   pend_d;
  logic               irq_q,    irq_d;

  // ---------------------------------------------------------------------------
  // Bus write decode
  // ---------------------------------------------------------------------------
  logic wr_s;
  logic wr_ctrl_s;
  logic wr_presc_s;
  logic wr_reload_s;
  logic wr_count_s;
  logic wr_status_s;

  assign wr_s = sel & we;

  // One-hot register write strobes; offsets 5-7 decode to nothing.
  always_comb begin
    wr_ctrl_s   = 1'b0;
    wr_presc_s  = 1'b0;
    wr_reload_s = 1'b0;
    wr_count_s  = 1'b0;
    wr_status_s = 1'b0;
    if (wr_s) begin
      case (addr)
        TMR_CTRL:   wr_ctrl_s   = 1'b1;
        TMR_PRESC:  wr_presc_s  = 1'b1;
        TMR_RELOAD: wr_reload_s = 1'b1;
        TMR_COUNT:  wr_count_s  = 1'b1;
        TMR_STATUS: wr_status_s = 1'b1;
        default:    wr_ctrl_s   = 1'b0;
      endcase
    end else begin
      wr_ctrl_s = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  logic tick_s;
  logic presc_clr_s;
  logic expire_s;

  // Restart the prescaler when the timer is being switched on, or when the
  // period changes under a running timer, so the next tick is a full period.
  assign presc_clr_s = (wr_ctrl_s & wdata[CTRL_EN] & ~ctrl_q.en) |
                       (wr_presc_s & ctrl_q.en);

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctrl_q.en),
    .clr   (presc_clr_s),
    .presc (presc_q),
    .tick  (tick_s)
  );

  // Expiry is judged on the counter value before any same-cycle COUNT write.
  assign expire_s = tick_s & (count_q == '0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  // CTRL: a bus write always wins over the one-shot auto-disable.
  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl_s) begin
      ctrl_d.en      = wdata[CTRL_EN];
      ctrl_d.auto_rl = wdata[CTRL_AUTO];
      ctrl_d.ie      = wdata[CTRL_IE];
    end else if (expire_s && !ctrl_q.auto_rl) begin
      ctrl_d.en = 1'b0;
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // PRESC and RELOAD are plain bus registers.
  always_comb begin
    presc_d  = presc_q;
    reload_d = reload_q;
    if (wr_presc_s) begin
      presc_d = wdata[PRESC_W-1:0];
    end else begin
      presc_d = presc_q;
    end
    if (wr_reload_s) begin
      reload_d = wdata;
    end else begin
      reload_d = reload_q;
    end
  end

  // COUNT: a bus write replaces whatever the tick would have done this cycle.
  // A one-shot expiry leaves the counter parked at zero.
  always_comb begin
    count_d = count_q;
    if (wr_count_s) begin
      count_d = wdata;
    end else if (tick_s) begin
      if (count_q != '0) begin
        count_d = count_q - DATA_W'(1);
      end else if (ctrl_q.auto_rl) begin
        count_d = reload_q;
      end else begin
        count_d = count_q;
      end
    end else begin
      count_d = count_q;
    end
  end

  // PEND: sticky; a new expiry beats a simultaneous write-1-to-clear.
  always_comb begin
    pend_d = pend_q;
    if (expire_s) begin
      pend_d = 1'b1;
    end else if (wr_status_s && wdata[STATUS_PEND]) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // The interrupt is computed from next-state values so the registered output
  // follows PEND & IE with no extra cycle and no path from the bus inputs.
  assign irq_d = pend_d & ctrl_d.ie;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Timer register file and interrupt output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      presc_q  <= '0;
      reload_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
    end
  end

  assign int_timer = irq_q;

  // ---------------------------------------------------------------------------
  // Read-back mux
  // ---------------------------------------------------------------------------

  // Zero-latency register read; unselected or unmapped offsets return zero.
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        TMR_CTRL: begin
          rdata[CTRL_EN]   = ctrl_q.en;
          rdata[CTRL_AUTO] = ctrl_q.auto_rl;
          rdata[CTRL_IE]   = ctrl_q.ie;
        end
        TMR_PRESC:  rdata[PRESC_W-1:0]  = presc_q;
        TMR_RELOAD: rdata               = reload_q;
        TMR_COUNT:  rdata               = count_q;
        TMR_STATUS: rdata[STATUS_PEND]  = pend_q;
        default:    rdata               = '0;
      endcase
    end else begin
      rdata = '0;
    end
  end

endmodule : bus_timer

// File: tb/tb_bus_timer.sv
// -----------------------------------------------------------------------------
// tb_bus_timer
// Scoreboard bench for bus_timer. The driver issues one bus cycle per clock,
// predicts rdata / int_timer from a transaction-level model of the timer and
// pushes the prediction; a monitor pops it later in the same cycle and
// compares against the DUT. Directed scenarios are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_bus_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        we;
  logic [2:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        int_timer;

  bus_timer #(
    .DATA_W  (16),
    .PRESC_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .int_timer (int_timer)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic last_irq = 1'b0;

  typedef struct {
    logic [15:0] rdata;
    logic        irq;
    logic [2:0]  addr;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state (timer as seen from the bus).
  logic        m_en, m_auto, m_ie, m_pend;
  logic [15:0] m_presc, m_reload, m_count;
  int          m_run;   // cycles spent enabled since the prescaler last restarted

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_auto = 1'b0; m_ie = 1'b0; m_pend = 1'b0;
    m_presc = 16'h0; m_reload = 16'h0; m_count = 16'h0; m_run = 0;
  endtask

  function automatic logic [15:0] m_read(input logic s, input logic [2:0] a);
    if (!s) return 16'h0;
    case (a)
      3'd0:    return {13'd0, m_ie, m_auto, m_en};
      3'd1:    return m_presc;
      3'd2:    return m_reload;
      3'd3:    return m_count;
      3'd4:    return {15'd0, m_pend};
      default: return 16'h0;
    endcase
  endfunction

  // One clock of timer behaviour: ticks land every PRESC+1 enabled cycles.
  task automatic model_step(input logic s, input logic w, input logic [2:0] a, input logic [15:0] d);
    logic tick, expire, restart;
    logic n_en, n_auto, n_ie, n_pend;
    logic [15:0] n_presc, n_reload, n_count;
    tick    = m_en && ((m_run % (int'(m_presc) + 1)) == int'(m_presc));
    expire  = tick && (m_count == 16'd0);
    restart = 1'b0;
    n_en = m_en; n_auto = m_auto; n_ie = m_ie; n_pend = m_pend;
    n_presc = m_presc; n_reload = m_reload; n_count = m_count;
    if (tick) n_count = (m_count != 16'd0) ? m_count - 16'd1 : (m_auto ? m_reload : 16'd0);
    if (expire && !m_auto) n_en = 1'b0;
    if (s && w) begin
      case (a)
        3'd0: begin n_en = d[0]; n_auto = d[1]; n_ie = d[2]; restart = d[0] && !m_en; end
        3'd1: begin n_presc = d; restart = m_en; end
        3'd2: n_reload = d;
        3'd3: n_count = d;
        3'd4: if (d[0]) n_pend = 1'b0;
        default: ;
      endcase
    end
    if (expire) n_pend = 1'b1;
    m_run = (!m_en || restart) ? 0 : m_run + 1;
    m_en = n_en; m_auto = n_auto; m_ie = n_ie; m_pend = n_pend;
    m_presc = n_presc; m_reload = n_reload; m_count = n_count;
  endtask

  // Drive one bus cycle and queue the predicted response for the monitor.
  task automatic bus_cycle(input logic s, input logic w, input logic [2:0] a, input logic [15:0] d);
    exp_t e;
    @(negedge clk);
    #1;
    last_irq = int_timer;
    rst_n = 1'b1;
    sel = s; we = w; addr = a; wdata = d;
    e.rdata = m_read(s, a);
    e.irq   = m_pend & m_ie;
    e.addr  = a;
    sb_q.push_back(e);
    model_step(s, w, a, d);
    cyc++;
  endtask

  // Assert reset asynchronously in the middle of a read cycle.
  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    #1;
    last_irq = int_timer;
    rst_n = 1'b0;
    sel = 1'b1; we = 1'b0; addr = 3'($urandom_range(0, 7)); wdata = 16'($urandom);
    model_reset();
    e.rdata = 16'h0; e.irq = 1'b0; e.addr = addr;
    sb_q.push_back(e);
    cyc++;
    #1;
    check("reset_async_irq", {31'd0, int_timer}, 32'd0);
    check("reset_async_rdata", {16'd0, rdata}, 32'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus_cycle(1'b1, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'($urandom), 3'($urandom_range(0, 7)), 16'($urandom));
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [15:0] exp, input string name);
    bus_cycle(1'b1, 1'b0, a, 16'($urandom));
    #1;
    check(name, {16'd0, rdata}, {16'd0, exp});
  endtask

  // Idle until int_timer is seen high; returns the index of the edge that raised it.
  task automatic wait_rise(input int limit, input string name, output int edge_idx);
    edge_idx = -1;
    for (int i = 0; i < limit; i++) begin
      idle(1);
      if (last_irq) begin
        edge_idx = cyc - 2;
        break;
      end
    end
    if (edge_idx < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: int_timer never rose within %0d cycles", name, limit);
    end
  endtask

  function automatic logic [15:0] rand_data(input logic [2:0] a);
    logic [15:0] d;
    d = 16'($urandom);
    case (a)
      3'd1:    d = ($urandom_range(0, 15) != 0) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(0, 40));
      3'd2,
      3'd3:    d = ($urandom_range(0, 15) != 0) ? 16'($urandom_range(0, 6)) : 16'($urandom_range(0, 60));
      default: ;
    endcase
    return d;
  endfunction

  // Monitor: compare the queued prediction against the DUT mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("rdata@%0d", e.addr), {16'd0, rdata}, {16'd0, e.rdata});
        check("int_timer", {31'd0, int_timer}, {31'd0, e.irq});
      end
    end
  end

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en_edge, rise1, rise2, extra;
    int r;
    logic [2:0] a;
    logic [15:0] d;

    rst_n = 1'b0; sel = 1'b0; we = 1'b0; addr = 3'd0; wdata = 16'h0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state of every offset.
    for (int i = 0; i < 8; i++) rd_chk(3'(i), 16'h0000, "reset_read");

    // Auto-reload: period (4+1)*(3+1) = 20 cycles.
    wr(3'd1, 16'd3);
    wr(3'd2, 16'd4);
    wr(3'd3, 16'd4);
    wr(3'd0, 16'h0007);
    en_edge = cyc - 1;
    wait_rise(60, "auto_first_rise", rise1);
    check("auto_first_latency", 32'(rise1 - en_edge), 32'd20);
    wr(3'd4, 16'h0001);
    idle(1);
    check("w1c_drop", {31'd0, last_irq}, 32'd0);
    wait_rise(60, "auto_second_rise", rise2);
    check("auto_period", 32'(rise2 - rise1), 32'd20);

    // One-shot: PRESC=0, COUNT=2 -> expiry three ticks after enable.
    wr(3'd0, 16'h0000);
    wr(3'd4, 16'h0001);
    wr(3'd1, 16'd0);
    wr(3'd3, 16'd2);
    wr(3'd0, 16'h0005);
    en_edge = cyc - 1;
    wait_rise(20, "oneshot_rise", rise1);
    check("oneshot_latency", 32'(rise1 - en_edge), 32'd3);
    rd_chk(3'd0, 16'h0004, "oneshot_en_cleared");
    wr(3'd4, 16'h0001);
    extra = 0;
    for (int i = 0; i < 50; i++) begin
      idle(1);
      if (last_irq) extra++;
    end
    check("oneshot_no_reexpire", 32'(extra), 32'd0);
    rd_chk(3'd3, 16'h0000, "oneshot_count_zero");

    // W1C on the exact expiry cycle: set wins.
    wr(3'd3, 16'd1);
    wr(3'd0, 16'h0005);
    idle(1);
    wr(3'd4, 16'h0001);
    rd_chk(3'd4, 16'h0001, "set_wins_pend");
    check("set_wins_irq", {31'd0, last_irq}, 32'd1);

    // COUNT write on a tick cycle: write wins, no decrement.
    wr(3'd0, 16'h0000);
    wr(3'd4, 16'h0001);
    wr(3'd3, 16'h0500);
    wr(3'd0, 16'h0003);
    idle(3);
    wr(3'd3, 16'h0100);
    rd_chk(3'd3, 16'h0100, "count_write_wins");

    // Masking: expiry with IE=0, then IE re-enabled.
    wr(3'd0, 16'h0000);
    wr(3'd4, 16'h0001);
    wr(3'd3, 16'h0000);
    wr(3'd0, 16'h0001);
    idle(4);
    check("masked_irq", {31'd0, last_irq}, 32'd0);
    rd_chk(3'd4, 16'h0001, "masked_pend");
    wr(3'd0, 16'h0004);
    idle(1);
    check("ie_reassert", {31'd0, last_irq}, 32'd1);
    rd_chk(3'd6, 16'h0000, "unmapped_read");
    wr(3'd6, 16'hFFFF);
    rd_chk(3'd6, 16'h0000, "unmapped_write_ignored");

    // Reset mid-run with the interrupt asserted.
    wr(3'd1, 16'd1);
    wr(3'd2, 16'd2);
    wr(3'd0, 16'h0007);
    idle(5);
    do_reset();
    for (int i = 0; i < 8; i++) rd_chk(3'(i), 16'h0000, "post_reset_read");
    idle(30);
    check("post_reset_quiet", {31'd0, last_irq}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      a = 3'($urandom_range(0, 7));
      d = rand_data(a);
      if (r < 2)        do_reset();
      else if (r < 550) bus_cycle(1'b0, 1'($urandom), a, d);
      else if (r < 800) bus_cycle(1'b1, 1'b0, a, d);
      else              bus_cycle(1'b1, 1'b1, a, d);
    end

    @(negedge clk);
    #4;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bus_timer

// File: doc/bus_timer.md
Name: bus_timer

Overview:
Memory-mapped 16-bit down-counting timer on the SoC data bus. It generates the `int_timer` request that feeds the CPU interrupt vector.
- Programmable prescaler, reload value, one-shot or auto-reload mode, and a sticky pending flag with write-1-to-clear.
- Instantiated inside BUS, which decodes its address window and drives `sel`/`we`/`addr`/`wdata`.

Parameters:
DATA_W, 16, bus data width and counter/reload width
PRESC_W, 16, prescaler register width (≤ DATA_W)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
sel  in  1  block selected by BUS address decode
we  in  1  write strobe, valid when sel=1
addr  in  3  word offset within the timer window
wdata  in  DATA_W  write data
rdata  out  DATA_W  read data, combinational from registers
int_timer  out  1  level interrupt request to CPU int[0]

Behaviour:
- Reset (async, rst_n=0): CTRL=0, PRESC=0, RELOAD=0, COUNT=0, PEND=0, prescaler counter pcnt=0. Outputs: int_timer=0, rdata=0.
- Register map (addr):
  - 0 CTRL: bit0 EN, bit1 AUTO, bit2 IE; other bits read 0.
  - 1 PRESC.
  - 2 RELOAD.
  - 3 COUNT: write loads the counter directly.
  - 4 STATUS: bit0 PEND; write 1 to clear.
  - 5–7: reads return 0, writes are ignored.
- Writes take effect on the clock edge where sel & we are both 1. With sel=0, rdata=0. Reads have zero latency.
- Prescaler:
  - When EN=1, pcnt increments each cycle.
  - When pcnt==PRESC: pcnt<=0 and a one-cycle tick fires, giving tick period PRESC+1.
  - When EN=0, pcnt holds at 0.
  - A CTRL write with EN rising 0→1 forces pcnt<=0.
  - A PRESC write while running also clears pcnt.
- Counter, on each tick:
  - COUNT≠0: COUNT<=COUNT-1.
  - COUNT==0: expiry. PEND<=1. If AUTO=1, COUNT<=RELOAD. If AUTO=0, EN<=0 and COUNT stays 0 (one-shot).
  - Auto-reload period = (RELOAD+1)*(PRESC+1) cycles.
- Simultaneous events:
  - A COUNT write in the same cycle as a tick: the write wins and no decrement occurs. Expiry is evaluated on the pre-write value, so PEND may still set.
  - A CTRL write in the same cycle as a one-shot expiry: the written EN wins.
  - A STATUS W1C in the same cycle as expiry: set wins, PEND stays 1.
- int_timer = PEND & IE, decoded from registers with no combinational path from bus inputs. It rises the cycle after the expiring tick edge and stays high until PEND is cleared or IE=0.
- Clearing IE does not clear PEND. Re-setting IE with PEND=1 reasserts int_timer immediately.
- Wrap/width:
  - All arithmetic is modulo 2^DATA_W.
  - PRESC=0 gives a tick every cycle.
  - RELOAD=0 with AUTO expires on every tick.
- Reset mid-count aborts everything. No interrupt is produced after reset until the timer is reprogrammed.

Decomposition:
- Shared para include:
  - register offsets TMR_CTRL/TMR_PRESC/TMR_RELOAD/TMR_COUNT/TMR_STATUS;
  - CTRL bit indices EN/AUTO/IE;
  - the existing DATABUS width macro.
- One natural sub-module, timer_prescaler: inputs clk, rst_n, en, clr, presc; output tick.
- Counter, registers and readback mux live in bus_timer.

Test Plan:
- Reset values: assert rst_n=0 mid-run → all reads return 0, int_timer=0 within the same cycle (async).
- Auto-reload: PRESC=3, RELOAD=4, CTRL=0b111 → PEND/int_timer first rise 20 cycles after enable, then every 20 cycles. Writing STATUS=1 drops int_timer next cycle.
- One-shot: PRESC=0, COUNT=2, CTRL=0b101 → int_timer rises after 3 cycles. EN reads 0 and COUNT stays 0 with no further expiry over 50 cycles.
- Set/clear collision: STATUS=1 write issued on the exact expiry tick cycle → PEND remains 1.
- COUNT write vs tick: PRESC=0, running, write COUNT=0x0100 on a tick cycle → next read 0x0100, not 0x00FF.
- Masking: IE=0 through expiry → PEND=1, int_timer=0. Set IE → int_timer=1 the following cycle. Unmapped addr 6 reads 0x0000.
